fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Downstream read stage for a show-ahead fifo (SHOWAHEAD=1, single clock). Drains the fifo
//  into a valid/ready stream framed as bursts: BURST_LEN words with sop/eop when enough
//  data is buffered, or a short burst of whatever is present after TIMEOUT idle cycles
//  or on flush_i. Feeds the packet/DMA egress logic.
// PARAMETERS
//  DWIDTH     32  data word width, equal to the fifo DWIDTH
//  AWIDTH     4   fifo address width; fifo_usedw_i is AWIDTH+1 bits
//  BURST_LEN  8   words per full burst; 1 <= BURST_LEN <= 2**AWIDTH
//  TIMEOUT    16  cycles in ARM before a short burst is forced; >= 1
// PORTS
//  clk_i         in   1          clock, all logic on rising edge
//  arst_n_i      in   1          reset, asynchronous assert, active-low
//  fifo_q_i      in   DWIDTH     fifo show-ahead head word, valid while !fifo_empty_i
//  fifo_empty_i  in   1          fifo empty flag
//  fifo_usedw_i  in   AWIDTH+1   fifo fill level
//  fifo_rdreq_o  out  1          pop request, combinational
//  flush_i       in   1          request an immediate short burst of buffered data
//  data_o        out  DWIDTH     stream data
//  valid_o       out  1          stream valid
//  ready_i       in   1          stream ready; a beat transfers when valid_o && ready_i
//  sop_o         out  1          first word of burst, qualified by valid_o
//  eop_o         out  1          last word of burst, qualified by valid_o
// BEHAVIOUR
//  Reset (arst_n_i=0, async):
//   - state=IDLE; valid_o, sop_o, eop_o = 0; data_o = 0.
//   - fifo_rdreq_o = 0; timer, len and popped counters = 0.
//   - A reset mid-burst drops the burst. No eop is issued for it.
//  Output register: a single stage holding data/valid/sop/eop.
//   - slot_free = !valid_o || ready_i.
//   - While valid_o && !ready_i, data_o, sop_o and eop_o hold stable.
//  FSM states:
//   IDLE:
//    - if !fifo_empty_i, go to ARM with timer=0.
//   ARM:
//    - timer increments every cycle.
//    - if fifo_usedw_i >= BURST_LEN: len=BURST_LEN, go to SEND. This check has priority.
//    - else if flush_i, or timer==TIMEOUT-1: len=fifo_usedw_i, clamped to BURST_LEN.
//      If len==0, go to IDLE; otherwise go to SEND.
//    - the length is latched into len (width $clog2(BURST_LEN+1)) and popped=0.
//   SEND:
//    - fifo_rdreq_o = (popped < len) && !fifo_empty_i && slot_free.
//    - on each pop, the output register loads fifo_q_i with valid_o=1,
//      sop_o = (popped==0) and eop_o = (popped==len-1); popped increments.
//    - if slot_free and no pop occurs, valid_o clears.
//    - when the eop beat transfers: go to ARM (timer=0) if !fifo_empty_i, else go to IDLE.
//  Protocol rules:
//   - fifo_rdreq_o is never asserted while fifo_empty_i=1.
//   - Throughput is 1 word/cycle when ready_i=1 and data is present.
//   - Pop-to-valid latency is 1 cycle: the word popped in cycle N is on data_o in N+1.
//   - flush_i is ignored outside ARM.
//   - Every burst has exactly one sop and one eop. A 1-word burst has sop=eop=1 on the same beat.
//   - Word order is preserved; no word is duplicated or dropped.
//   - All counters are sized so they cannot wrap within legal parameters.
// TESTING
//  1 Reset: arst_n_i low mid-burst -> all outputs 0 immediately; after release, state is IDLE and fifo_rdreq_o=0.
//  2 Full burst: write 8 words 0..7, ready_i=1 -> 8 beats on consecutive cycles; sop on 0, eop on 7;
//    fifo_rdreq_o high exactly 8 cycles.
//  3 Timeout: write 3 words, TIMEOUT=16 -> burst starts 16 cycles after ARM entry;
//    3 beats, sop on word 0, eop on word 2.
//  4 Backpressure: 8-word burst, ready_i toggling 1,0,0,1 -> data_o/sop_o/eop_o stable while stalled;
//    no pop while the slot is full; all 8 words arrive in order.
//  5 Flush and edge cases:
//    - flush_i pulse in ARM with 1 word -> single beat with sop=eop=1.
//    - flush_i in IDLE -> no effect.
//  6 Back-to-back: 20 words written continuously -> bursts of 8 and 8, then a 4-word timeout burst;
//    no gaps within bursts when ready_i=1.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Read stage for a show-ahead fifo: drains buffered words as sop/eop framed bursts
// on a valid/ready stream, either full BURST_LEN bursts or short bursts on timeout/flush.
//
// state | meaning
// IDLE  | fifo empty, nothing to do
// ARM   | data buffered, waiting for a full burst, a flush or the timeout
// SEND  | popping len words into the output register and streaming them
module fifo_burst_reader #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 4,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  input  logic              flush_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sop_o,
  output logic              eop_o
);

  localparam int LW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam logic [LW-1:0]   BURST_LEN_L  = LW'(BURST_LEN);
  localparam logic [AWIDTH:0] BURST_LEN_U  = (AWIDTH + 1)'(BURST_LEN);
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     popped_q, popped_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;

  logic              slot_free;
  logic              pop;
  logic              eop_xfer;
  logic [LW-1:0]     usedw_clamp;

  assign slot_free   = !valid_q || ready_i;
  assign pop         = (state_q == ST_SEND) && (popped_q < len_q) && !fifo_empty_i && slot_free;
  assign eop_xfer    = valid_q && ready_i && eop_q;
  assign usedw_clamp = (fifo_usedw_i >= BURST_LEN_U) ? BURST_LEN_L : LW'(fifo_usedw_i);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    len_d    = len_q;
    popped_d = popped_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_i) begin
          state_d = ST_ARM;
          timer_d = '0;
        end
      end
      ST_ARM: begin
        timer_d = timer_q + 1'b1;
        // A full burst wins over flush and timeout in the same cycle.
        if (fifo_usedw_i >= BURST_LEN_U) begin
          len_d    = BURST_LEN_L;
          popped_d = '0;
          state_d  = ST_SEND;
        end else if (flush_i || (timer_q == TIMEOUT_LAST)) begin
          len_d    = usedw_clamp;
          popped_d = '0;
          state_d  = (usedw_clamp == '0) ? ST_IDLE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (pop) begin
          popped_d = popped_q + 1'b1;
        end
        if (eop_xfer) begin
          state_d = fifo_empty_i ? ST_IDLE : ST_ARM;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (pop) begin
      data_d  = fifo_q_i;
      valid_d = 1'b1;
      sop_d   = (popped_q == '0);
      eop_d   = (popped_q == (len_q - 1'b1));
    end else if (slot_free) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      len_q    <= '0;
      popped_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      len_q    <= len_d;
      popped_q <= popped_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  assign fifo_rdreq_o = pop;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign sop_o        = sop_q;
  assign eop_o        = eop_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based show-ahead fifo, a behavioural burst model
// compared every cycle, a word-order scoreboard and literal scenario expectations.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BL = 8;
  localparam int TO = 16;
  localparam int DEPTH = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_BURST = 2;

  logic          clk;
  logic          arst_n_i;
  logic [DW-1:0] fifo_q_i;
  logic          fifo_empty_i;
  logic [AW:0]   fifo_usedw_i;
  logic          fifo_rdreq_o;
  logic          flush_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          sop_o;
  logic          eop_o;

  fifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_usedw_i (fifo_usedw_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .flush_i      (flush_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .sop_o        (sop_o),
    .eop_o        (eop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [31:0] d;
    logic        s;
    logic        e;
  } beat_t;

  logic [31:0] fq[$];
  logic [31:0] sb[$];
  beat_t       blog[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int rd_cnt   = 0;
  int rd_first = -1;
  bit pop_pend = 1'b0;

  // model state
  int          m_phase, m_wait, m_len, m_pops, cnt;
  bit          m_v, m_s, m_e, slot, e_rd, eop_go;
  logic [31:0] m_d, head;
  bit          prev_v, prev_r, prev_s, prev_e;
  logic [31:0] prev_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i = (fq.size() == 0);
    fifo_q_i     = (fq.size() > 0) ? fq[0] : '0;
    fifo_usedw_i = (AW + 1)'(fq.size());
  endtask

  // One clock: apply the pop seen at this edge, an optional write, then new inputs.
  task automatic step(input bit wr, input logic [31:0] wd, input bit rdy, input bit fl);
    logic [31:0] tmp;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_pend) begin
      n_checks++;
      if (fq.size() == 0) begin
        n_err++;
        $display("FAIL pop_from_empty: rdreq with empty fifo (cycle %0d)", cyc);
      end else begin
        tmp = fq.pop_front();
      end
    end
    if (wr && fq.size() < DEPTH) begin
      fq.push_back(wd);
      sb.push_back(wd);
    end
    drive_fifo();
    ready_i = rdy;
    flush_i = fl;
  endtask

  task automatic quiesce(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic clear_log();
    blog.delete();
    rd_cnt   = 0;
    rd_first = -1;
  endtask

  // Per-cycle compare against the behavioural model, sampled well before the next edge.
  always begin
    @(posedge clk);
    #7;
    if (!arst_n_i) begin
      m_phase = PH_IDLE; m_wait = 0; m_len = 0; m_pops = 0;
      m_v = 0; m_s = 0; m_e = 0; m_d = '0;
      pop_pend = 1'b0;
      prev_v = 1'b0;
    end else begin
      cnt  = fq.size();
      head = (cnt > 0) ? fq[0] : '0;
      slot = !m_v || ready_i;
      e_rd = (m_phase == PH_BURST) && (m_pops < m_len) && (cnt > 0) && slot;

      chk("rdreq", fifo_rdreq_o, e_rd);
      chk("valid", valid_o, m_v);
      if (m_v) begin
        chk("data", data_o, m_d);
        chk("sop", sop_o, m_s);
        chk("eop", eop_o, m_e);
      end
      chk("rdreq_while_empty", fifo_rdreq_o && fifo_empty_i, 1'b0);
      chk("pop_into_full_slot", fifo_rdreq_o && valid_o && !ready_i, 1'b0);
      if (prev_v && !prev_r) begin
        chk("stall_valid", valid_o, 1'b1);
        chk("stall_data", data_o, prev_d);
        chk("stall_sop", sop_o, prev_s);
        chk("stall_eop", eop_o, prev_e);
      end
      if (valid_o && ready_i) begin
        blog.push_back('{c: cyc, d: data_o, s: sop_o, e: eop_o});
        if (sb.size() == 0) chk("order_extra_word", data_o, 32'hDEAD_BEEF);
        else chk("order", data_o, sb.pop_front());
      end
      if (fifo_rdreq_o) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = cyc;
      end
      prev_v = valid_o; prev_r = ready_i; prev_d = data_o; prev_s = sop_o; prev_e = eop_o;
      pop_pend = fifo_rdreq_o;

      eop_go = m_v && ready_i && m_e;
      if (e_rd) begin
        m_v = 1; m_d = head; m_s = (m_pops == 0); m_e = (m_pops == m_len - 1);
        m_pops++;
      end else if (slot) begin
        m_v = 0;
      end
      case (m_phase)
        PH_IDLE: if (cnt > 0) begin m_phase = PH_WAIT; m_wait = 0; end
        PH_WAIT: begin
          if (cnt >= BL) begin
            m_phase = PH_BURST; m_len = BL; m_pops = 0;
          end else if (flush_i || m_wait == TO - 1) begin
            m_len = (cnt < BL) ? cnt : BL;
            m_pops = 0;
            m_phase = (m_len == 0) ? PH_IDLE : PH_BURST;
          end else begin
            m_wait++;
          end
        end
        default: if (eop_go) begin m_phase = (cnt > 0) ? PH_WAIT : PH_IDLE; m_wait = 0; end
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    int t0, nb, gaps, blen, seen;
    int lens[$];
    arst_n_i = 1'b0;
    ready_i  = 1'b1;
    flush_i  = 1'b0;
    drive_fifo();

    // reset state
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_sop", sop_o, 1'b0);
    chk("rst_eop", eop_o, 1'b0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_rdreq", fifo_rdreq_o, 1'b0);
    arst_n_i = 1'b1;
    quiesce(3);

    // full burst
    clear_log();
    t0 = cyc + 1;
    for (int i = 0; i < 8; i++) step(1'b1, i, 1'b1, 1'b0);
    quiesce(20);
    chk("full_nbeats", blog.size(), 8);
    chk("full_rdreq_cycles", rd_cnt, 8);
    chk("full_first_pop", rd_first - t0, 8);
    if (blog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("full_data", blog[i].d, i);
        chk("full_sop", blog[i].s, i == 0);
        chk("full_eop", blog[i].e, i == 7);
        chk("full_beat_cycle", blog[i].c - t0, 9 + i);
      end
    end

    // timeout short burst
    clear_log();
    t0 = cyc + 1;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + i, 1'b1, 1'b0);
    quiesce(30);
    chk("to_nbeats", blog.size(), 3);
    chk("to_first_pop", rd_first - t0, 17);
    if (blog.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("to_data", blog[i].d, 32'h30 + i);
        chk("to_sop", blog[i].s, i == 0);
        chk("to_eop", blog[i].e, i == 2);
        chk("to_beat_cycle", blog[i].c - t0, 18 + i);
      end
    end

    // backpressure with ready pattern 1,0,0,1
    clear_log();
    for (int j = 0; j < 60; j++)
      step(j < 8, 32'h40 + j, (j % 4 == 0) || (j % 4 == 3), 1'b0);
    quiesce(5);
    chk("bp_nbeats", blog.size(), 8);
    if (blog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("bp_data", blog[i].d, 32'h40 + i);
        chk("bp_sop", blog[i].s, i == 0);
        chk("bp_eop", blog[i].e, i == 7);
      end
    end

    // flush in ARM with one word
    clear_log();
    t0 = cyc + 1;
    step(1'b1, 32'h55, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    quiesce(20);
    chk("flush_nbeats", blog.size(), 1);
    if (blog.size() == 1) begin
      chk("flush_data", blog[0].d, 32'h55);
      chk("flush_sop", blog[0].s, 1'b1);
      chk("flush_eop", blog[0].e, 1'b1);
      chk("flush_beat_cycle", blog[0].c - t0, 5);
    end

    // flush in IDLE
    clear_log();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1);
    quiesce(5);
    chk("idle_flush_beats", blog.size(), 0);
    chk("idle_flush_rdreq", rd_cnt, 0);

    // back-to-back: 20 words
    clear_log();
    for (int i = 0; i < 20; i++) step(1'b1, 32'h60 + i, 1'b1, 1'b0);
    quiesce(50);
    nb = 0; gaps = 0; blen = 0;
    lens.delete();
    for (int i = 0; i < blog.size(); i++) begin
      if (blog[i].s) blen = 0;
      else if (i > 0 && blog[i].c != blog[i-1].c + 1) gaps++;
      blen++;
      if (blog[i].e) begin nb++; lens.push_back(blen); end
    end
    chk("b2b_nbeats", blog.size(), 20);
    chk("b2b_nbursts", nb, 3);
    chk("b2b_gaps", gaps, 0);
    if (lens.size() == 3) begin
      chk("b2b_len0", lens[0], 8);
      chk("b2b_len1", lens[1], 8);
      chk("b2b_len2", lens[2], 4);
    end
    for (int i = 0; i < blog.size(); i++) chk("b2b_data", blog[i].d, 32'h60 + i);

    // reset in the middle of a burst
    for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + i, 1'b1, 1'b0);
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (valid_o) seen = 1;
    end
    chk("rst_burst_started", seen, 1);
    step(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    arst_n_i = 1'b0;
    fq.delete();
    sb.delete();
    drive_fifo();
    #1;
    chk("mid_rst_valid", valid_o, 1'b0);
    chk("mid_rst_sop", sop_o, 1'b0);
    chk("mid_rst_eop", eop_o, 1'b0);
    chk("mid_rst_data", data_o, 32'h0);
    chk("mid_rst_rdreq", fifo_rdreq_o, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    arst_n_i = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    chk("rel_rdreq", fifo_rdreq_o, 1'b0);
    chk("rel_valid", valid_o, 1'b0);
    quiesce(3);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 1) == 1 && fq.size() < DEPTH - 1, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);

    // drain, bounded
    seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (fq.size() == 0 && sb.size() == 0 && !valid_o) seen = 1;
    end
    chk("drain_done", seen, 1);
    chk("drain_sb_empty", sb.size(), 0);
    quiesce(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
